lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store unit that consumes the `mem_rd`/`mem_wr`/`mask` controls from the main decoder and performs the data-memory transaction. It sits in the execute/memory stage, between the ALU result and rs2 operand and a single-outstanding request/grant data bus. It aligns write lanes, generates byte enables, and extracts and sign- or zero-extends load data. It stalls the core until each access completes.

## Interface
- `ADDR_W`, default 32: bus address width.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `mem_rd_i`, input, 1: load request from the decoder.
- `mem_wr_i`, input, 1: store request from the decoder.
- `mask_i`, input, 3: funct3 access size/sign.
- `addr_i`, input, ADDR_W: byte address (ALU result).
- `wdata_i`, input, 32: store data (rs2).
- `stall_o`, output, 1: hold the pipeline.
- `rdata_o`, output, 32: extended load result.
- `rdata_valid_o`, output, 1: one-cycle load-complete strobe.
- `misalign_o`, output, 1: misaligned-access flag (see Configuration).
- `bus_req_o`, output, 1: bus request.
- `bus_we_o`, output, 1: 1 = write.
- `bus_addr_o`, output, ADDR_W: word-aligned address; bits [1:0] are always 0.
- `bus_be_o`, output, 4: byte enables.
- `bus_wdata_o`, output, 32: lane-aligned write data.
- `bus_gnt_i`, input, 1: request accepted.
- `bus_rvalid_i`, input, 1: read data valid.
- `bus_rdata_i`, input, 32: read data.

## Operation
- **FSM states:** IDLE, REQ, WAIT_R, DONE.
- **IDLE**
  - If `mem_rd_i | mem_wr_i`, assert `stall_o` combinationally.
  - Latch the address, mask, aligned write data and byte enables, then go to REQ.
  - If both `mem_rd_i` and `mem_wr_i` are set, the load wins.
- **REQ**
  - Drive `bus_req_o`=1. Hold address, `we`, `be` and `wdata` stable until `bus_gnt_i`.
  - On grant: a store goes to DONE; a load goes to WAIT_R.
- **WAIT_R:** on `bus_rvalid_i`, capture the extracted, extended data into `rdata_o` and go to DONE.
- **DONE**
  - `stall_o`=0. `rdata_valid_o`=1 for loads only.
  - Request inputs are ignored this cycle. Return to IDLE.
- **Mask encodings**
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - 011, 110 and 111 are treated as W.
  - Stores ignore `mask_i[2]`.
- **Byte enables**
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
- **Write data:** B is `{4{wdata[7:0]}}`, H is `{2{wdata[15:0]}}`, W is unchanged.
- **Load extraction**
  - Select the byte lane `addr[1:0]` or the half lane `addr[1]`.
  - B and H sign-extend from bit 7 or bit 15. BU and HU zero-extend.
- **Misalignment:** a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0, is misaligned. Handling depends on configuration.
- **Output values**
  - `rdata_o` holds its last value between loads.
  - Outside REQ, `bus_*` outputs are 0.
- **Reset values:** all outputs 0; FSM in IDLE.
- **Reset mid-operation:** the transaction is abandoned. A late `bus_rvalid_i` or `bus_gnt_i` arriving in IDLE is ignored.
- **Ignored bus inputs:** `bus_rvalid_i` in REQ and `bus_gnt_i` outside REQ are ignored.

## Timing
- **Store, grant in the first REQ cycle:** request seen at cycle 0, REQ at cycle 1, DONE at cycle 2. `stall_o` is high in cycles 0–1.
- **Load, rvalid one cycle after grant:** IDLE at 0, REQ at 1, WAIT_R at 2, DONE at 3. `rdata_valid_o` and the new `rdata_o` appear in cycle 3.
- **Earliest rvalid:** the cycle after grant.
- **Wait states:** each extra cycle of grant or rvalid delay adds one stall cycle.
- **Back-to-back:** the next request is accepted in the IDLE cycle following DONE, so there is at least one idle bus cycle between accesses.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined**
  - A misaligned request in IDLE raises `misalign_o` for exactly one cycle.
  - No bus access is made, `stall_o` stays 0, the FSM stays in IDLE, and `rdata_o` is unchanged.
- **`LSU_MISALIGN_TRAP_EN` undefined**
  - `misalign_o` is tied to 0.
  - Misaligned accesses proceed with the low address bits truncated: halfwords use `addr[1]` only; words use lane 0.

## Structure
- **Shared package `riscv_pkg`:** holds the mask/funct3 encoding enum (`MASK_B`, `MASK_H`, `MASK_W`, `MASK_BU`, `MASK_HU`) and the LSU state enum, both shared with the main decoder.
- **Sub-module `lsu_align`:** combinational; computes byte enables, write-lane replication and load extract/extend. The FSM stays in `lsu_ctrl`.

## Test plan
- **SW, immediate grant:** SW `addr`=0x100, `wdata`=0xDEADBEEF, `gnt` in the first REQ cycle → `be`=1111, `bus_addr`=0x100, `we`=1, 2 stall cycles, `rdata_valid` stays 0.
- **SB to lane 3:** SB `addr`=0x103, `wdata`=0x000000A5 → `be`=1000, `bus_wdata`=0xA5A5A5A5.
- **LB and LBU:** LB `addr`=0x201, `rdata`=0x0000F000 → `rdata_o`=0xFFFFFFF0. LBU at the same address → 0x000000F0. In both cases `rdata_valid` is high in cycle 3.
- **LH with delays:** LH `addr`=0x202, `gnt` delayed 2 cycles, `rvalid` delayed 3 cycles, `rdata`=0x80010000 → `rdata_o`=0xFFFF8001. `bus_addr`/`be` are held stable while waiting. Stall lasts 2+3+1 cycles.
- **Misaligned LW:** LW `addr`=0x302 → with the macro: `misalign_o` pulses 1 cycle, no `bus_req`. Without the macro: `bus_addr`=0x300, `be`=1111.
- **Reset mid-load:** `rst_n` low during WAIT_R, then `rvalid` arrives after reset → outputs return to 0, FSM in IDLE, `rdata_valid` never asserts.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the main decoder and the load/store unit
// Contents: funct3 access-mask enum, LSU FSM state enum, and a misalignment helper.
// Access size always comes from mask[1:0] (00 = byte, 01 = half, 1x = word).
// mask[2] only selects zero-extension for loads.
package riscv_pkg;

  typedef enum logic [2:0] {
    MASK_B  = 3'b000,
    MASK_H  = 3'b001,
    MASK_W  = 3'b010,
    MASK_BU = 3'b100,
    MASK_HU = 3'b101
  } mask_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_R,
    LSU_DONE
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'b01) ? off[0] : (size[1] & (|off));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit
// Ports:
//   st_off_i / st_size_i / wdata_i -> be_o, wdata_o : store byte enables and lane-replicated data
//   ld_off_i / ld_mask_i / rdata_i -> rdata_o       : load lane extraction with sign/zero extension
// Halfwords use only off[1] and words ignore the offset, so misaligned
// accesses are truncated rather than split.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_mask_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    be_o    = (st_size_i == 2'b00) ? 4'b0001 << st_off_i :
              (st_size_i == 2'b01) ? 4'b0011 << {st_off_i[1], 1'b0} : 4'b1111;
    wdata_o = (st_size_i == 2'b00) ? {4{wdata_i[7:0]}} :
              (st_size_i == 2'b01) ? {2{wdata_i[15:0]}} : wdata_i;
    b       = rdata_i[{ld_off_i, 3'b000} +: 8];
    h       = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sx      = !(ld_mask_i == MASK_BU || ld_mask_i == MASK_HU);
    rdata_o = (ld_mask_i[1:0] == 2'b00) ? {{24{sx & b[7]}}, b} :
              (ld_mask_i[1:0] == 2'b01) ? {{16{sx & h[15]}}, h} : rdata_i;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between execute stage and data bus
// Ports:
//   mem_rd_i, mem_wr_i, mask_i, addr_i, wdata_i : access request from decoder/ALU/rs2
//   stall_o, rdata_o, rdata_valid_o, misalign_o : pipeline stall, load result, status
//   bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, bus_gnt_i, bus_rvalid_i, bus_rdata_i : data bus
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned requests pulse misalign_o
// and skip the bus; otherwise they proceed with low address bits truncated.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [2:0]        mask_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        mask_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              mis_q;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       ext;
  logic              req;
  logic              mis;
  logic              go;

  assign req = mem_rd_i | mem_wr_i;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = is_misaligned(mask_i[1:0], addr_i[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign go  = req & ~mis & (state_q == LSU_IDLE);

  lsu_align u_align (
    .st_off_i  (addr_i[1:0]),
    .st_size_i (mask_i[1:0]),
    .wdata_i   (wdata_i),
    .be_o      (be_d),
    .wdata_o   (wdata_d),
    .ld_off_i  (addr_q[1:0]),
    .ld_mask_i (mask_q),
    .rdata_i   (bus_rdata_i),
    .rdata_o   (ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= LSU_IDLE;
      addr_q   <= '0;
      mask_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      // a held misaligned request still yields a single-cycle pulse
      mis_q    <= (state_q == LSU_IDLE) & req & mis & ~mis_q;
      case (state_q)
        LSU_IDLE: if (go) begin
          addr_q  <= addr_i;
          mask_q  <= mask_i;
          we_q    <= mem_wr_i & ~mem_rd_i;
          be_q    <= be_d;
          wdata_q <= wdata_d;
          state_q <= LSU_REQ;
        end
        LSU_REQ: if (bus_gnt_i) state_q <= we_q ? LSU_DONE : LSU_WAIT_R;
        LSU_WAIT_R: if (bus_rvalid_i) begin
          rdata_q  <= ext;
          rvalid_q <= 1'b1;
          state_q  <= LSU_DONE;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign stall_o       = go | (state_q == LSU_REQ) | (state_q == LSU_WAIT_R);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign misalign_o    = mis_q;
  assign bus_req_o     = state_q == LSU_REQ;
  assign bus_we_o      = bus_req_o & we_q;
  assign bus_addr_o    = bus_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o      = bus_req_o ? be_q : '0;
  assign bus_wdata_o   = bus_req_o ? wdata_q : '0;

endmodule
